// File: rtl/jtag_pkg.sv
// rtl/jtag_pkg.sv - shared encodings for the JTAG-to-AHB bridge
// Contents: AHB-Lite HTRANS/HSIZE/HBURST encodings, bridge FSM state enum,
// request-type enum and the TAP IR opcodes that drive the bridge strobes.
package jtag_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    // TAP instruction opcodes whose DR updates produce ADDR_WR/DATA_WR/RD_REQ
    localparam logic [3:0] IR_ADDR   = 4'h8;
    localparam logic [3:0] IR_DATA   = 4'h9;
    localparam logic [3:0] IR_READ   = 4'hA;
    localparam logic [3:0] IR_BYPASS = 4'hF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADDR_PH = 2'd1,
        DATA_PH = 2'd2
    } state_t;

    typedef enum logic {
        WR = 1'b0,
        RD = 1'b1
    } req_t;

endpackage

// File: rtl/jtag_ahb_master.sv
// rtl/jtag_ahb_master.sv - single-beat AHB-Lite master driven by JTAG strobes
// Ports:
//   TCK/TRST                 clock, synchronous active-high reset
//   ADDR_WR/ADDR_IN          load address register
//   DATA_WR/DATA_IN, RD_REQ  write / read requests (one-cycle pulses)
//   ERR_CLR                  clear sticky ERR and OVF
//   RDATA_OUT/RDATA_VALID    captured read data and its pulse
//   BUSY, DONE, ERR, OVF     status
//   H*                       AHB-Lite master interface
module jtag_ahb_master
    import jtag_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int AUTO_INC   = 1
) (
    input  logic                  TCK,
    input  logic                  TRST,
    input  logic                  ADDR_WR,
    input  logic [ADDR_WIDTH-1:0] ADDR_IN,
    input  logic                  DATA_WR,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    input  logic                  RD_REQ,
    input  logic                  ERR_CLR,
    output logic [DATA_WIDTH-1:0] RDATA_OUT,
    output logic                  RDATA_VALID,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERR,
    output logic                  OVF,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic                  HWRITE,
    output logic [1:0]            HTRANS,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [DATA_WIDTH-1:0] HWDATA,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_n;
    logic [ADDR_WIDTH-1:0] haddr_q, haddr_n;
    logic                  hwrite_q, hwrite_n;
    logic [DATA_WIDTH-1:0] hwdata_q, hwdata_n;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_n;
    logic                  rvalid_q, rvalid_n;
    logic                  done_q, done_n;
    logic                  err_q, err_n;
    logic                  ovf_q, ovf_n;
    logic                  pend_valid, pend_valid_n;
    req_t                  pend_type, pend_type_n;
    logic [DATA_WIDTH-1:0] pend_data, pend_data_n;

    logic                  complete;
    logic                  issue;
    req_t                  issue_type;
    logic [DATA_WIDTH-1:0] issue_data;
    logic                  err_set;
    logic                  ovf_set;

    always_ff @(posedge TCK) begin
        if (TRST) begin
            state      <= IDLE;
            addr_reg   <= '0;
            haddr_q    <= '0;
            hwrite_q   <= 1'b0;
            hwdata_q   <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
            pend_valid <= 1'b0;
            pend_type  <= WR;
            pend_data  <= '0;
        end else begin
            state      <= state_n;
            addr_reg   <= addr_n;
            haddr_q    <= haddr_n;
            hwrite_q   <= hwrite_n;
            hwdata_q   <= hwdata_n;
            rdata_q    <= rdata_n;
            rvalid_q   <= rvalid_n;
            done_q     <= done_n;
            err_q      <= err_n;
            ovf_q      <= ovf_n;
            pend_valid <= pend_valid_n;
            pend_type  <= pend_type_n;
            pend_data  <= pend_data_n;
        end
    end

    always_comb begin
        state_n      = state;
        haddr_n      = haddr_q;
        hwrite_n     = hwrite_q;
        hwdata_n     = hwdata_q;
        rdata_n      = rdata_q;
        rvalid_n     = 1'b0;
        done_n       = 1'b0;
        pend_valid_n = pend_valid;
        pend_type_n  = pend_type;
        pend_data_n  = pend_data;
        issue        = 1'b0;
        issue_type   = WR;
        issue_data   = DATA_IN;
        ovf_set      = 1'b0;

        complete = (state == DATA_PH) && HREADY;
        err_set  = (state == DATA_PH) && HRESP;

        // A fresh ADDR_WR beats the post-transfer increment; the address a
        // newly issued transfer uses is always this next-cycle value.
        if (ADDR_WR) begin
            addr_n = ADDR_IN;
        end else if (complete && !HRESP && (AUTO_INC != 0)) begin
            addr_n = addr_reg + ADDR_WIDTH'(4);
        end else begin
            addr_n = addr_reg;
        end

        case (state)
            IDLE: begin
                if (DATA_WR || RD_REQ) begin
                    issue      = 1'b1;
                    issue_type = DATA_WR ? WR : RD;
                    // The read half of a simultaneous write+read is parked.
                    if (DATA_WR && RD_REQ) begin
                        if (!pend_valid) begin
                            pend_valid_n = 1'b1;
                            pend_type_n  = RD;
                        end else begin
                            ovf_set = 1'b1;
                        end
                    end
                end
            end
            ADDR_PH: begin
                if (HREADY) begin
                    state_n = DATA_PH;
                end
            end
            DATA_PH: begin
                if (HREADY) begin
                    done_n = 1'b1;
                    if (!hwrite_q && !HRESP) begin
                        rvalid_n = 1'b1;
                        rdata_n  = HRDATA;
                    end
                    if (pend_valid) begin
                        issue        = 1'b1;
                        issue_type   = pend_type;
                        issue_data   = pend_data;
                        pend_valid_n = 1'b0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // While busy, new requests compete for the single slot. The slot
        // counts as full for the whole cycle it drains, so a request in that
        // cycle is dropped rather than refilling it.
        if (state != IDLE && (DATA_WR || RD_REQ)) begin
            if (!pend_valid) begin
                pend_valid_n = 1'b1;
                pend_type_n  = DATA_WR ? WR : RD;
                pend_data_n  = DATA_IN;
                ovf_set      = DATA_WR && RD_REQ;
            end else begin
                ovf_set = 1'b1;
            end
        end

        if (issue) begin
            state_n  = ADDR_PH;
            haddr_n  = addr_n;
            hwrite_n = (issue_type == WR);
            if (issue_type == WR) begin
                hwdata_n = issue_data;
            end
        end

        err_n = err_set ? 1'b1 : (ERR_CLR ? 1'b0 : err_q);
        ovf_n = ovf_set ? 1'b1 : (ERR_CLR ? 1'b0 : ovf_q);
    end

    assign HTRANS      = (state == ADDR_PH) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HSIZE       = HSIZE_WORD;
    assign HBURST      = HBURST_SINGLE;
    assign HADDR       = haddr_q;
    assign HWRITE      = hwrite_q;
    assign HWDATA      = hwdata_q;
    assign RDATA_OUT   = rdata_q;
    assign RDATA_VALID = rvalid_q;
    assign DONE        = done_q;
    assign ERR         = err_q;
    assign OVF         = ovf_q;
    assign BUSY        = (state != IDLE) || pend_valid;

endmodule

// File: doc/jtag_ahb_master.md
JTAG_AHB_MASTER -- requirements
Module: jtag_ahb_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning the width of the address register and HADDR.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning the width of the data/read paths.
REQ-003 SHALL have parameter AUTO_INC, default 1, meaning the address advances by 4 after each completed transfer (0 disables).
REQ-004 SHALL use one clock, TCK; reset TRST is synchronous and active-high.
REQ-005 TCK  in  1  clock (the JTAG test clock); TRST  in  1  synchronous active-high reset.
REQ-006 ADDR_WR  in  1  one-cycle pulse, load ADDR_IN (from address-IR DR update).
REQ-007 ADDR_IN  in  ADDR_WIDTH  address shifted in by the TAP.
REQ-008 DATA_WR  in  1  one-cycle pulse, request a write of DATA_IN; DATA_IN  in  DATA_WIDTH.
REQ-009 RD_REQ  in  1  one-cycle pulse, request a read; ERR_CLR  in  1  clears ERR and OVF.
REQ-010 RDATA_OUT  out  DATA_WIDTH  captured read data; RDATA_VALID  out  1  one-cycle pulse.
REQ-011 BUSY  out  1; DONE  out  1 (one-cycle pulse per completed transfer); ERR  out  1 (sticky); OVF  out  1 (sticky).
REQ-012 HADDR  out  ADDR_WIDTH; HWRITE  out  1; HTRANS  out  2; HSIZE  out  3; HBURST  out  3; HWDATA  out  DATA_WIDTH.
REQ-013 HRDATA  in  DATA_WIDTH; HREADY  in  1; HRESP  in  1 (AHB-Lite, 0=OKAY, 1=ERROR).

Function
REQ-014 FSM states SHALL be IDLE, ADDR_PH, DATA_PH; HSIZE fixed 3'b010, HBURST fixed 3'b000 (SINGLE).
REQ-015 IDLE: HTRANS=IDLE(00); on a request (or pending slot valid) -> ADDR_PH, HTRANS=NONSEQ(10), HADDR=address register, HWRITE=1 for write/0 for read.
REQ-016 ADDR_PH: hold HADDR/HWRITE/HTRANS stable until HREADY=1 sampled; then -> DATA_PH, HTRANS=IDLE.
REQ-017 DATA_PH: HWDATA = latched write data; hold until HREADY=1 sampled; then DONE pulse, -> IDLE (or ADDR_PH directly if pending slot valid, back-to-back).
REQ-018 Latency: request sampled at edge k with HREADY=1 throughout -> NONSEQ during cycle k..k+1, data phase k+1..k+2, DONE/RDATA_VALID high during cycle k+2..k+3.
REQ-019 Read completion SHALL capture HRDATA into RDATA_OUT at the completing edge and pulse RDATA_VALID with DONE.
REQ-020 One-deep pending slot SHALL hold one request (type, data) arriving while BUSY; a further request while slot full SHALL be dropped and set OVF.
REQ-021 BUSY = (state != IDLE) or pending slot valid.
REQ-022 ADDR_WR SHALL update the address register immediately; in-flight transfer keeps its latched HADDR; simultaneous ADDR_WR and DATA_WR/RD_REQ: new address used for that request.
REQ-023 Simultaneous DATA_WR and RD_REQ: write accepted, read goes to pending slot (or dropped with OVF if slot full).
REQ-024 AUTO_INC=1: address register += 4 on OKAY completion, modulo 2^ADDR_WIDTH (0xFFFFFFFC -> 0x00000000); a same-cycle ADDR_WR wins over increment.
REQ-025 HRESP=1 in DATA_PH: set ERR, complete on the HREADY=1 edge of the two-cycle error response, no address increment, RDATA_VALID not pulsed; pending slot still issued.
REQ-026 ERR_CLR SHALL clear ERR and OVF; a same-cycle set wins over clear.

Reset
REQ-027 TRST at any edge SHALL force IDLE, HTRANS=00, HWRITE=0, HADDR=0, HWDATA=0, address register 0, pending slot empty, RDATA_OUT=0, RDATA_VALID=0, DONE=0, BUSY=0, ERR=0, OVF=0.
REQ-028 TRST mid-transfer SHALL abandon the transfer without DONE; requests in the reset cycle are ignored.

Structure
REQ-029 Shared package jtag_pkg SHALL hold HTRANS/HSIZE/HBURST encodings, the FSM state enum, the request-type enum (WR, RD) and IR opcode constants used by jtag.
REQ-030 Single module, no sub-module; pending slot and address counter are in-module registers.

Verification
REQ-031 ADDR_WR 0x00001000, then DATA_WR 0xDEADBEEF, HREADY=1 -> NONSEQ HADDR=0x1000 HWRITE=1, next cycle HWDATA=0xDEADBEEF, DONE after 2 cycles, address=0x1004.
REQ-032 RD_REQ at 0x2000, HRDATA=0x12345678, HREADY low 3 cycles in DATA_PH -> RDATA_OUT=0x12345678, RDATA_VALID one cycle, address 0x2004.
REQ-033 Three DATA_WR pulses on consecutive cycles -> two back-to-back transfers (0x0, 0x4), third dropped, OVF=1.
REQ-034 Address 0xFFFFFFFC write OKAY -> address 0x00000000; HRESP ERROR two-cycle response -> ERR=1, address unchanged, ERR_CLR clears it.
REQ-035 TRST asserted during ADDR_PH with HREADY=0 -> next cycle HTRANS=00, BUSY=0, no DONE, all outputs at reset values.
